// File: rtl/knn_label_vote_pkg.sv
// knn_pkg: types and defaults shared by the neighbour-vote datapath.
//   dist_t / label_t  - default-width distance and label as produced by the sorter
//   vote_state_e      - control states of the vote block
//   CNT_W, cnt_width  - width of counters that must hold values 0..K without wrapping
package knn_pkg;

  localparam int K_DEF           = 5;
  localparam int NUM_CLASSES_DEF = 4;
  localparam int LABEL_W_DEF     = 2;
  localparam int DIST_W_DEF      = 16;

  localparam int CNT_W = $clog2(K_DEF + 1);

  typedef logic [DIST_W_DEF-1:0]  dist_t;
  typedef logic [LABEL_W_DEF-1:0] label_t;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    VOTE,
    OUT
  } vote_state_e;

  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_label_vote_if.sv
// knn_label_vote_if: neighbour input stream plus classification result stream.
//   in_valid/in_ready/in_dist/in_label/in_last  - ascending (distance, label) stream
//   out_valid/out_ready/out_label/out_count     - one result per query
//   out_short/out_sort_err/out_label_err        - per-query status flags
// master = stream producer / result consumer, slave = vote block.
interface knn_label_vote_if
  import knn_pkg::*;
#(
  parameter int DIST_W  = DIST_W_DEF,
  parameter int LABEL_W = LABEL_W_DEF,
  parameter int CNT_W   = knn_pkg::CNT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [DIST_W-1:0]  in_dist;
  logic [LABEL_W-1:0] in_label;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [LABEL_W-1:0] out_label;
  logic [CNT_W-1:0]   out_count;
  logic               out_short;
  logic               out_sort_err;
  logic               out_label_err;

  modport master (
    output in_valid, in_dist, in_label, in_last, out_ready,
    input  in_ready, out_valid, out_label, out_count,
           out_short, out_sort_err, out_label_err
  );

  modport slave (
    input  in_valid, in_dist, in_label, in_last, out_ready,
    output in_ready, out_valid, out_label, out_count,
           out_short, out_sort_err, out_label_err
  );

endinterface

// File: rtl/knn_label_vote_histogram.sv
// label_histogram: per-class vote counts and rank of each class's nearest member.
//   clk, rst          - clock, synchronous active-high reset
//   clear             - zero all counts (end of query)
//   inc, inc_label    - add one vote for inc_label (caller guarantees it is in range)
//   inc_rank          - rank of the voting element, captured on a class's first vote
//   rd_class          - class to read; rd_count / rd_first_rank are its entries
module label_histogram
  import knn_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int LABEL_W     = LABEL_W_DEF,
  parameter int CW          = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  input  logic [LABEL_W-1:0] inc_label,
  input  logic [CW-1:0]      inc_rank,
  input  logic [LABEL_W-1:0] rd_class,
  output logic [CW-1:0]      rd_count,
  output logic [CW-1:0]      rd_first_rank
);

  logic [CW-1:0] count_q [NUM_CLASSES];
  logic [CW-1:0] first_q [NUM_CLASSES];

  // NOTE: this is a handful of flops, not a RAM, so it is reset like any other
  // state; a stale count from an aborted query would otherwise corrupt the vote.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        count_q[c] <= '0;
        first_q[c] <= '0;
      end
    end else if (inc) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (inc_label == LABEL_W'(c)) begin
          count_q[c] <= count_q[c] + CW'(1);
          if (count_q[c] == '0) first_q[c] <= inc_rank;
        end
      end
    end
  end

  // NOTE: defaults first so the read mux can never infer a latch.
  always_comb begin
    rd_count      = '0;
    rd_first_rank = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (rd_class == LABEL_W'(c)) begin
        rd_count      = count_q[c];
        rd_first_rank = first_q[c];
      end
    end
  end

endmodule

// File: rtl/knn_label_vote.sv
// knn_label_vote: keeps the K nearest (distance, label) entries of a sorted stream
// and majority-votes their labels, ties going to the class with the nearest member.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - knn_label_vote_if slave: neighbour stream in, result stream out
module knn_label_vote
  import knn_pkg::*;
#(
  parameter int K           = K_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int LABEL_W     = LABEL_W_DEF,
  parameter int DIST_W      = DIST_W_DEF
) (
  input logic             clk,
  input logic             rst,
  knn_label_vote_if.slave bus
);

  localparam int CW = cnt_width(K);

  vote_state_e        state_q, state_d;
  logic [CW-1:0]      rank_q;
  logic [DIST_W-1:0]  prev_dist_q;
  logic               sort_err_q, label_err_q, short_q;
  logic [LABEL_W-1:0] scan_q;
  logic [LABEL_W-1:0] best_label_q;
  logic [CW-1:0]      best_count_q, best_rank_q;
  logic [LABEL_W-1:0] out_label_q;
  logic [CW-1:0]      out_count_q;
  logic               out_short_q, out_sort_err_q, out_label_err_q;

  logic               in_ready, accept, in_range, hist_inc, hist_clear;
  logic               last_class, take;
  logic [CW-1:0]      rd_count, rd_first_rank;
  logic [LABEL_W-1:0] cand_label;
  logic [CW-1:0]      cand_count, cand_rank;

  // Extra bit so NUM_CLASSES == 2**LABEL_W does not wrap to zero.
  assign in_range   = {1'b0, bus.in_label} < (LABEL_W + 1)'(NUM_CLASSES);
  assign accept     = bus.in_valid && in_ready;
  assign hist_inc   = (state_q == ACCUM) && accept && in_range;
  assign hist_clear = (state_q == OUT) && bus.out_ready;
  assign last_class = (scan_q == LABEL_W'(NUM_CLASSES - 1));

  label_histogram #(
    .NUM_CLASSES (NUM_CLASSES),
    .LABEL_W     (LABEL_W),
    .CW          (CW)
  ) u_hist (
    .clk           (clk),
    .rst           (rst),
    .clear         (hist_clear),
    .inc           (hist_inc),
    .inc_label     (bus.in_label),
    .inc_rank      (rank_q),
    .rd_class      (scan_q),
    .rd_count      (rd_count),
    .rd_first_rank (rd_first_rank)
  );

  // A class with zero votes never wins, so an all-invalid query reports class 0.
  assign take = (rd_count > best_count_q) ||
                ((rd_count == best_count_q) && (rd_count != '0) &&
                 (rd_first_rank < best_rank_q));
  assign cand_label = take ? scan_q        : best_label_q;
  assign cand_count = take ? rd_count      : best_count_q;
  assign cand_rank  = take ? rd_first_rank : best_rank_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_last)                state_d = VOTE;
          else if (rank_q == CW'(K - 1))  state_d = DRAIN;
        end
      end
      DRAIN: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = VOTE;
      end
      VOTE: if (last_class)    state_d = OUT;
      OUT:  if (bus.out_ready) state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rank_q          <= '0;
      prev_dist_q     <= '0;
      sort_err_q      <= 1'b0;
      label_err_q     <= 1'b0;
      short_q         <= 1'b0;
      scan_q          <= '0;
      best_label_q    <= '0;
      best_count_q    <= '0;
      best_rank_q     <= CW'(K);
      out_label_q     <= '0;
      out_count_q     <= '0;
      out_short_q     <= 1'b0;
      out_sort_err_q  <= 1'b0;
      out_label_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM, DRAIN: begin
          // Vote scan starts fresh; rank K beats no real rank in the tie-break.
          scan_q       <= '0;
          best_label_q <= '0;
          best_count_q <= '0;
          best_rank_q  <= CW'(K);
          if (state_q == ACCUM && accept) begin
            rank_q      <= rank_q + CW'(1);
            prev_dist_q <= bus.in_dist;
            if (!in_range) label_err_q <= 1'b1;
            if (rank_q != '0 && bus.in_dist < prev_dist_q) sort_err_q <= 1'b1;
            if (bus.in_last && (rank_q + CW'(1)) < CW'(K)) short_q <= 1'b1;
          end
        end
        VOTE: begin
          scan_q       <= scan_q + LABEL_W'(1);
          best_label_q <= cand_label;
          best_count_q <= cand_count;
          best_rank_q  <= cand_rank;
          if (last_class) begin
            out_label_q     <= cand_label;
            out_count_q     <= cand_count;
            out_short_q     <= short_q;
            out_sort_err_q  <= sort_err_q;
            out_label_err_q <= label_err_q;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            rank_q      <= '0;
            sort_err_q  <= 1'b0;
            label_err_q <= 1'b0;
            short_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = (state_q == OUT);
  assign bus.out_label     = out_label_q;
  assign bus.out_count     = out_count_q;
  assign bus.out_short     = out_short_q;
  assign bus.out_sort_err  = out_sort_err_q;
  assign bus.out_label_err = out_label_err_q;

endmodule

// File: tb/tb_knn_label_vote.sv
// Bench for knn_label_vote with K=3, four classes and 3-bit labels (4..7 invalid).
module tb_knn_label_vote;

  localparam int K      = 3;
  localparam int NC     = 4;
  localparam int LW     = 3;
  localparam int DW     = 16;
  localparam int CW     = $clog2(K + 1);
  localparam int MAXN   = 8;
  localparam int LIMIT  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  knn_label_vote_if #(.DIST_W(DW), .LABEL_W(LW), .CNT_W(CW)) bus ();

  knn_label_vote #(
    .K           (K),
    .NUM_CLASSES (NC),
    .LABEL_W     (LW),
    .DIST_W      (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q_d [MAXN];
  logic [LW-1:0] q_l [MAXN];

  typedef struct {
    string       name;
    int          n;
    int unsigned d [6];
    int unsigned l [6];
    int unsigned e_label;
    int unsigned e_count;
    bit          e_short;
    bit          e_sort;
    bit          e_lerr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: look only at the first K elements; the winner is the class with the
  // most votes, and among equals the one that appears earliest in the stream.
  task automatic model(input int n, output int e_label, output int e_count,
                       output bit e_short, output bit e_sort, output bit e_lerr);
    int m;
    int votes [NC];
    int maxv;
    m       = (n < K) ? n : K;
    e_short = (n < K);
    e_sort  = 0;
    e_lerr  = 0;
    for (int c = 0; c < NC; c++) votes[c] = 0;
    for (int i = 0; i < m; i++) begin
      if (int'(q_l[i]) >= NC) e_lerr = 1;
      else votes[q_l[i]]++;
      if (i > 0 && q_d[i] < q_d[i-1]) e_sort = 1;
    end
    maxv = 0;
    for (int c = 0; c < NC; c++) if (votes[c] > maxv) maxv = votes[c];
    e_label = 0;
    e_count = maxv;
    if (maxv > 0) begin
      for (int i = m - 1; i >= 0; i--)
        if (int'(q_l[i]) < NC && votes[q_l[i]] == maxv) e_label = int'(q_l[i]);
    end
  endtask

  task automatic send(input string nm, input logic [DW-1:0] d, input logic [LW-1:0] l,
                      input bit last);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_dist  = d;
    bus.in_label = l;
    bus.in_last  = last;
    while (!bus.in_ready && guard < LIMIT) begin
      @(posedge clk); #1;
      guard++;
    end
    check({nm, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_query(input string nm, input int n, input int hold,
                           input int e_label, input int e_count,
                           input bit e_short, input bit e_sort, input bit e_lerr);
    int lat;
    bit stable;
    logic [LW-1:0] l0;
    logic [CW-1:0] c0;
    logic [2:0]    f0;
    for (int i = 0; i < n; i++) send(nm, q_d[i], q_l[i], i == n - 1);
    lat = 0;
    while (!bus.out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, NC);
    check({nm, "_label"}, bus.out_label, e_label);
    check({nm, "_count"}, bus.out_count, e_count);
    check({nm, "_short"}, bus.out_short, e_short);
    check({nm, "_sort_err"}, bus.out_sort_err, e_sort);
    check({nm, "_label_err"}, bus.out_label_err, e_lerr);
    if (hold > 0) begin
      stable = 1;
      l0 = bus.out_label;
      c0 = bus.out_count;
      f0 = {bus.out_short, bus.out_sort_err, bus.out_label_err};
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!bus.out_valid || bus.in_ready || bus.out_label !== l0 || bus.out_count !== c0 ||
            {bus.out_short, bus.out_sort_err, bus.out_label_err} !== f0)
          stable = 0;
      end
      check({nm, "_hold_stable"}, stable, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, "_released"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  task automatic add_vec(input string nm, input int n,
                         input int unsigned d0, d1, d2, d3, d4,
                         input int unsigned l0, l1, l2, l3, l4,
                         input int unsigned el, ec, input bit es, eso, ele);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4; v.d[5] = 0;
    v.l[0] = l0; v.l[1] = l1; v.l[2] = l2; v.l[3] = l3; v.l[4] = l4; v.l[5] = 0;
    v.e_label = el;
    v.e_count = ec;
    v.e_short = es;
    v.e_sort  = eso;
    v.e_lerr  = ele;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int el, ec, n, hold, d;
    bit es, eso, ele;

    bus.in_valid  = 1'b0;
    bus.in_dist   = '0;
    bus.in_label  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    //       name          n  distances          labels           lbl cnt sh so le
    add_vec("majority",    5, 1, 2, 3, 4, 5,     2, 1, 2, 0, 0,   2,  2,  0, 0, 0);
    add_vec("tie_nearest", 3, 10, 11, 12, 0, 0,  3, 1, 0, 0, 0,   3,  1,  0, 0, 0);
    add_vec("short_one",   1, 7, 0, 0, 0, 0,     1, 0, 0, 0, 0,   1,  1,  1, 0, 0);
    add_vec("sort_err",    3, 5, 3, 9, 0, 0,     0, 0, 1, 0, 0,   0,  2,  0, 1, 0);
    add_vec("bad_label",   3, 1, 2, 3, 0, 0,     3, 7, 3, 0, 0,   3,  2,  0, 0, 1);
    add_vec("all_invalid", 3, 1, 2, 3, 0, 0,     5, 6, 7, 0, 0,   0,  0,  0, 0, 1);
    add_vec("drain_nochk", 4, 1, 2, 3, 0, 0,     1, 1, 2, 3, 0,   1,  2,  0, 0, 0);
    add_vec("equal_dist",  3, 4, 4, 4, 0, 0,     2, 2, 1, 0, 0,   2,  2,  0, 0, 0);
    add_vec("short_tie",   2, 1, 2, 0, 0, 0,     0, 1, 0, 0, 0,   0,  1,  1, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_outputs", {bus.out_label, bus.out_count, bus.out_short,
                            bus.out_sort_err, bus.out_label_err}, 0);

    // Table vectors.
    foreach (tbl[i]) begin
      for (int j = 0; j < 6; j++) begin
        q_d[j] = DW'(tbl[i].d[j]);
        q_l[j] = LW'(tbl[i].l[j]);
      end
      run_query(tbl[i].name, tbl[i].n, 0, tbl[i].e_label, tbl[i].e_count,
                tbl[i].e_short, tbl[i].e_sort, tbl[i].e_lerr);
    end

    // Back-pressure: result held for 10 cycles, next query right after release.
    q_d[0] = 20; q_l[0] = 1;
    q_d[1] = 21; q_l[1] = 3;
    q_d[2] = 22; q_l[2] = 3;
    run_query("backpressure", 3, 10, 3, 2, 0, 0, 0);
    q_d[0] = 2; q_l[0] = 0;
    q_d[1] = 3; q_l[1] = 2;
    q_d[2] = 4; q_l[2] = 0;
    run_query("after_bp", 3, 0, 0, 2, 0, 0, 0);

    // Reset mid-query: two elements of a five-element query, then reset.
    send("pre_reset", 16'd1, 3'd1, 1'b0);
    send("pre_reset", 16'd2, 3'd1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      bit quiet;
      quiet = 1;
      for (int i = 0; i < 8; i++) begin
        if (bus.out_valid || !bus.in_ready) quiet = 0;
        @(posedge clk); #1;
      end
      check("reset_discard", quiet, 1);
    end
    q_d[0] = 1; q_l[0] = 2;
    q_d[1] = 2; q_l[1] = 3;
    q_d[2] = 3; q_l[2] = 2;
    run_query("post_reset", 3, 0, 2, 2, 0, 0, 0);

    // Randomized queries against the reference model.
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 6);
      d = $urandom_range(0, 50);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0 && d > 3) d = d - $urandom_range(1, 3);
        else d = d + $urandom_range(0, 4);
        q_d[i] = DW'(d);
        q_l[i] = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(4, 7))
                                             : LW'($urandom_range(0, NC - 1));
      end
      hold = $urandom_range(0, 3);
      model(n, el, ec, es, eso, ele);
      run_query($sformatf("rand%0d", t), n, hold, el, ec, es, eso, ele);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
